// File: rtl/tx_dac_pkg.sv
// tx_dac_pkg: shared widths, midscale constant, state enum and entry helpers for the Tx DAC formatter.
package tx_dac_pkg;
  localparam int SAMPLE_W = 12;
  localparam int TAG_W = 2;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;
  typedef enum logic {PRIME, RUN} state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
  function automatic entry_t pack_entry(input logic [TAG_W-1:0] tag, input logic [SAMPLE_W-1:0] i, input logic [SAMPLE_W-1:0] q);
    return '{tag: tag, i: i, q: q};
  endfunction
  function automatic logic [SAMPLE_W-1:0] to_ob(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction
endpackage

// File: rtl/tx_dac_fifo.sv
// tx_dac_fifo: single-clock FIFO with show-ahead head; a push while full is accepted only alongside a pop.
module tx_dac_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 26,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic full, push_en, pop_en;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign pop_en = pop && !empty;
  assign push_en = push && (!full || pop_en);
  always_comb begin
    wr_d = wr_q + AW'(push_en);
    rd_d = rd_q + AW'(pop_en);
    level_d = level_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  // Storage needs no reset: the cleared level already marks every slot invalid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign level = level_q;
endmodule

// File: rtl/tx_dac_formatter.sv
// tx_dac_formatter: buffers Tx I/Q samples and presents them to the DAC in offset binary on each request.
// Optional TX_DAC_STATS_EN enables saturating overflow/underrun counters.
module tx_dac_formatter
  import tx_dac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PREFILL = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_16M384,
  input  logic          rst_16M384,
  input  logic [11:0]   DAC_I,
  input  logic [11:0]   DAC_Q,
  input  logic [1:0]    DAC_bits,
  input  logic          DAC_vld,
  input  logic          dac_req,
  output logic [11:0]   dac_i_ob,
  output logic [11:0]   dac_q_ob,
  output logic [1:0]    dac_tag,
  output logic          dac_live,
  output logic [LW-1:0] fifo_level,
  output logic [15:0]   ovf_cnt,
  output logic [15:0]   udf_cnt
);
  state_t state_q, state_d;
  entry_t head;
  logic empty, pop, udf;
  logic [SAMPLE_W-1:0] i_q, i_d, q_q, q_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic live_q, live_d;
  tx_dac_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk(clk_16M384),
    .rst(rst_16M384),
    .push(DAC_vld),
    .pop(pop),
    .din(pack_entry(DAC_bits, DAC_I, DAC_Q)),
    .dout(head),
    .empty(empty),
    .level(fifo_level)
  );
  assign pop = state_q == RUN && dac_req && !empty;
  assign udf = state_q == RUN && dac_req && empty;
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) state_q <= PRIME;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == PRIME ? (fifo_level >= LW'(PREFILL) ? RUN : PRIME) : (udf ? PRIME : RUN);
  end
  always_comb begin
    i_d = pop ? to_ob(head.i) : udf ? MIDSCALE : i_q;
    q_d = pop ? to_ob(head.q) : udf ? MIDSCALE : q_q;
    tag_d = pop ? head.tag : udf ? '0 : tag_q;
    live_d = pop ? 1'b1 : udf ? 1'b0 : live_q;
  end
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      i_q <= MIDSCALE;
      q_q <= MIDSCALE;
      tag_q <= '0;
      live_q <= 1'b0;
    end else begin
      i_q <= i_d;
      q_q <= q_d;
      tag_q <= tag_d;
      live_q <= live_d;
    end
  end
  assign dac_i_ob = i_q;
  assign dac_q_ob = q_q;
  assign dac_tag = tag_q;
  assign dac_live = live_q;
`ifdef TX_DAC_STATS_EN
  logic [15:0] ovf_q, ovf_d, udf_q, udf_d;
  logic drop;
  // A full FIFO takes the push only when a pop frees a slot in the same cycle.
  assign drop = DAC_vld && fifo_level == LW'(DEPTH) && !pop;
  always_comb begin
    ovf_d = (drop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    udf_d = (udf && udf_q != 16'hFFFF) ? udf_q + 16'd1 : udf_q;
  end
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  assign ovf_cnt = ovf_q;
  assign udf_cnt = udf_q;
`else
  assign ovf_cnt = '0;
  assign udf_cnt = '0;
`endif
endmodule

// File: tb/tb_tx_dac_formatter.sv
// tb_tx_dac_formatter: directed stimulus with a request scoreboard checked by an independent output monitor.
module tb_tx_dac_formatter;
`ifdef TX_DAC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct packed {
    logic [11:0] i;
    logic [11:0] q;
    logic [1:0] t;
    logic l;
  } exp_t;
  logic clk, rst;
  logic [11:0] DAC_I, DAC_Q, dac_i_ob, dac_q_ob;
  logic [1:0] DAC_bits, dac_tag;
  logic DAC_vld, dac_req, dac_live;
  logic [3:0] fifo_level;
  logic [15:0] ovf_cnt, udf_cnt;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic req_s;

  tx_dac_formatter #(.DEPTH(8), .PREFILL(4)) dut (
    .clk_16M384(clk),
    .rst_16M384(rst),
    .DAC_I(DAC_I),
    .DAC_Q(DAC_Q),
    .DAC_bits(DAC_bits),
    .DAC_vld(DAC_vld),
    .dac_req(dac_req),
    .dac_i_ob(dac_i_ob),
    .dac_q_ob(dac_q_ob),
    .dac_tag(dac_tag),
    .dac_live(dac_live),
    .fifo_level(fifo_level),
    .ovf_cnt(ovf_cnt),
    .udf_cnt(udf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) req_s <= 1'b0;
    else req_s <= dac_req;
  end

  always @(negedge clk) begin
    if (req_s) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: request seen with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({dac_i_ob, dac_q_ob, dac_tag, dac_live} !== e) begin
          errors++;
          $display("FAIL dac_out: got i=%h q=%h tag=%0d live=%b, expected i=%h q=%h tag=%0d live=%b",
                   dac_i_ob, dac_q_ob, dac_tag, dac_live, e.i, e.q, e.t, e.l);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] i, input logic [11:0] q, input logic [1:0] t, input logic r);
    DAC_vld = v;
    DAC_I = i;
    DAC_Q = q;
    DAC_bits = t;
    dac_req = r;
    @(negedge clk);
    DAC_vld = 1'b0;
    dac_req = 1'b0;
  endtask

  task automatic expect_out(input logic [11:0] ei, input logic [11:0] eq, input logic [1:0] et, input logic el);
    exp_t e;
    e.i = ei;
    e.q = eq;
    e.t = et;
    e.l = el;
    sb.push_back(e);
  endtask

  task automatic rq(input logic [11:0] ei, input logic [11:0] eq, input logic [1:0] et, input logic el);
    expect_out(ei, eq, et, el);
    step(1'b0, 12'h0, 12'h0, 2'd0, 1'b1);
  endtask

  task automatic push(input logic [11:0] i, input logic [11:0] q, input logic [1:0] t);
    step(1'b1, i, q, t, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 12'h0, 12'h0, 2'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    DAC_vld = 1'b0;
    dac_req = 1'b0;
    DAC_I = '0;
    DAC_Q = '0;
    DAC_bits = '0;
    #12;
    chk("rst_i", dac_i_ob, 12'h800);
    chk("rst_q", dac_q_ob, 12'h800);
    chk("rst_tag", dac_tag, 0);
    chk("rst_live", dac_live, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_udf", udf_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    // PRIME ignores requests on an empty FIFO
    for (int n = 0; n < 48; n++) begin
      if (n % 16 == 15) rq(12'h800, 12'h800, 2'd0, 1'b0);
      else idle();
    end
    chk("prime_udf", udf_cnt, 0);
    chk("prime_level", fifo_level, 0);
    // extreme values convert to 000/FFF
    push(12'h800, 12'h7FF, 2'd2);
    push(12'h000, 12'h000, 2'd0);
    push(12'h000, 12'h000, 2'd0);
    push(12'h000, 12'h000, 2'd0);
    chk("prefill_level", fifo_level, 4);
    idle();
    rq(12'h000, 12'hFFF, 2'd2, 1'b1);
    idle();
    idle();
    chk("hold_i", dac_i_ob, 12'h000);
    chk("hold_live", dac_live, 1);
    rq(12'h800, 12'h800, 2'd0, 1'b1);
    rq(12'h800, 12'h800, 2'd0, 1'b1);
    rq(12'h800, 12'h800, 2'd0, 1'b1);
    rq(12'h800, 12'h800, 2'd0, 1'b0);
    chk("udf_first", udf_cnt, STATS ? 1 : 0);
    // four distinct samples then an underrun
    push(12'h001, 12'h005, 2'd1);
    push(12'hFFF, 12'hFFB, 2'd3);
    push(12'h064, 12'h7FF, 2'd0);
    push(12'hF9C, 12'h800, 2'd2);
    idle();
    rq(12'h801, 12'h805, 2'd1, 1'b1);
    idle();
    rq(12'h7FF, 12'h7FB, 2'd3, 1'b1);
    rq(12'h864, 12'hFFF, 2'd0, 1'b1);
    idle();
    rq(12'h79C, 12'h000, 2'd2, 1'b1);
    rq(12'h800, 12'h800, 2'd0, 1'b0);
    chk("udf_second", udf_cnt, STATS ? 2 : 0);
    chk("drained_level", fifo_level, 0);
    // ten pushes into an eight-deep FIFO
    for (int k = 0; k < 10; k++) push(12'(k), 12'hF00 | 12'(k), 2'(k));
    chk("full_level", fifo_level, 8);
    chk("ovf_two", ovf_cnt, STATS ? 2 : 0);
    // push and pop together at full
    expect_out(12'h800, 12'h700, 2'd0, 1'b1);
    step(1'b1, 12'h123, 12'hABC, 2'd3, 1'b1);
    chk("full_pushpop_level", fifo_level, 8);
    chk("full_pushpop_ovf", ovf_cnt, STATS ? 2 : 0);
    for (int k = 1; k < 8; k++) rq(12'h800 | 12'(k), 12'h700 | 12'(k), 2'(k), 1'b1);
    rq(12'h923, 12'h2BC, 2'd3, 1'b1);
    chk("empty_after_pops", fifo_level, 0);
    // asynchronous reset between edges
    push(12'h0AA, 12'h0BB, 2'd1);
    push(12'h0CC, 12'h0DD, 2'd2);
    push(12'h0EE, 12'h0FF, 2'd3);
    chk("pre_reset_level", fifo_level, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_i", dac_i_ob, 12'h800);
    chk("async_rst_q", dac_q_ob, 12'h800);
    chk("async_rst_tag", dac_tag, 0);
    chk("async_rst_live", dac_live, 0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_ovf", ovf_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    rq(12'h800, 12'h800, 2'd0, 1'b0);
    push(12'h111, 12'h222, 2'd1);
    push(12'h333, 12'h444, 2'd2);
    push(12'h555, 12'h666, 2'd3);
    rq(12'h800, 12'h800, 2'd0, 1'b0);
    chk("below_prefill_level", fifo_level, 3);
    push(12'h777, 12'h888, 2'd0);
    idle();
    rq(12'h911, 12'hA22, 2'd1, 1'b1);
    chk("post_reset_level", fifo_level, 3);
    chk("post_reset_udf", udf_cnt, 0);
    idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
